// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway_if: lookup/fill request, flush control and write-back port of the N-way dcache array
interface dcache_sram_nway_if #(
  parameter int SETS = 16,
  parameter int WAYS = 2,
  parameter int TAG_W = 23,
  parameter int LINE_W = 256
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  logic req_i;
  logic write_i;
  logic [SET_W-1:0] addr_i;
  logic [TAG_W-1:0] tag_i;
  logic [LINE_W-1:0] data_i;
  logic dirty_i;
  logic hit_o;
  logic [WAY_W-1:0] hit_way_o;
  logic [LINE_W-1:0] data_o;
  logic [TAG_W-1:0] tag_o;
  logic victim_valid_o;
  logic victim_dirty_o;
  logic flush_i;
  logic busy_o;
  logic done_o;
  logic wb_valid_o;
  logic wb_ready_i;
  logic [SET_W-1:0] wb_set_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic [LINE_W-1:0] wb_data_o;
  modport master (
    output req_i, write_i, addr_i, tag_i, data_i, dirty_i, flush_i, wb_ready_i,
    input hit_o, hit_way_o, data_o, tag_o, victim_valid_o, victim_dirty_o,
    input busy_o, done_o, wb_valid_o, wb_set_o, wb_tag_o, wb_data_o
  );
  modport slave (
    input req_i, write_i, addr_i, tag_i, data_i, dirty_i, flush_i, wb_ready_i,
    output hit_o, hit_way_o, data_o, tag_o, victim_valid_o, victim_dirty_o,
    output busy_o, done_o, wb_valid_o, wb_set_o, wb_tag_o, wb_data_o
  );
endinterface

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative dcache array with true-LRU replacement and a write-back flush walker
module dcache_sram_nway #(
  parameter int SETS = 16,
  parameter int WAYS = 2,
  parameter int TAG_W = 23,
  parameter int LINE_W = 256
) (
  input logic clk_i,
  input logic rst_i,
  dcache_sram_nway_if.slave bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_e;
  state_e state_q, state_d;
  logic [SET_W+WAY_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [LINE_W-1:0] line_q [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] dirty_d [SETS];
  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];
  logic [WAY_W-1:0] age_rst [SETS][WAYS];
  logic [SET_W-1:0] a, ws;
  logic [WAY_W-1:0] ww, hit_way, victim, sel;
  logic busy, active, hit, full, wr, acc, last, wb;
  assign a = bus.addr_i;
  assign ws = idx_q[SET_W+WAY_W-1:WAY_W];
  assign ww = idx_q[WAY_W-1:0];
  assign last = &idx_q;
  assign busy = state_q == SCAN || state_q == WB;
  assign wb = state_q == WB;
  assign active = bus.req_i && !busy;
  assign full = &valid_q[a];
  for (genvar s = 0; s < SETS; s++) begin : g_s
    for (genvar w = 0; w < WAYS; w++) begin : g_w
      assign age_rst[s][w] = WAY_W'(w);
    end
  end
  // Descending scan so the lowest matching/invalid way wins
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[a][w] && tag_q[a][w] == bus.tag_i) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (full ? age_q[a][w] == WAY_W'(WAYS - 1) : !valid_q[a][w]) victim = WAY_W'(w);
    end
  end
  assign sel = hit ? hit_way : victim;
  assign wr = active && bus.write_i;
  assign acc = active && (hit || bus.write_i);
  assign bus.hit_o = active && hit;
  assign bus.hit_way_o = active ? sel : '0;
  assign bus.data_o = active ? line_q[a][sel] : '0;
  assign bus.tag_o = active ? tag_q[a][sel] : '0;
  assign bus.victim_valid_o = active && !hit && valid_q[a][victim];
  assign bus.victim_dirty_o = active && !hit && valid_q[a][victim] && dirty_q[a][victim];
  assign bus.busy_o = busy;
  assign bus.done_o = state_q == DONE;
  assign bus.wb_valid_o = wb;
  assign bus.wb_set_o = wb ? ws : '0;
  assign bus.wb_tag_o = wb ? tag_q[ws][ww] : '0;
  assign bus.wb_data_o = wb ? line_q[ws][ww] : '0;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d = age_q;
    if (wr) begin
      valid_d[a][sel] = 1'b1;
      dirty_d[a][sel] = (hit && dirty_q[a][sel]) || bus.dirty_i;
    end
    if (acc)
      for (int w = 0; w < WAYS; w++)
        age_d[a][w] = WAY_W'(w) == sel ? '0 :
                      age_q[a][w] < age_q[a][sel] ? age_q[a][w] + WAY_W'(1) : age_q[a][w];
    case (state_q)
      SCAN, WB: begin
        if (state_q == SCAN && valid_q[ws][ww] && dirty_q[ws][ww]) state_d = WB;
        else if (state_q == SCAN || bus.wb_ready_i) begin
          valid_d[ws][ww] = 1'b0;
          dirty_d[ws][ww] = 1'b0;
          idx_d = idx_q + 1'b1;
          state_d = last ? DONE : SCAN;
        end
      end
      default: begin
        state_d = bus.flush_i ? SCAN : IDLE;
        idx_d = '0;
      end
    endcase
    if (state_d == DONE) age_d = age_rst;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      age_q <= age_rst;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      age_q <= age_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr && !hit) tag_q[a][sel] <= bus.tag_i;
    if (wr) line_q[a][sel] <= bus.data_i;
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: scoreboard bench for a 16x2 and an 8x4 dcache array against a timestamp-LRU model
module tb_dcache_sram_nway;
  typedef struct packed {
    logic hit;
    logic [2:0] way;
    logic vv;
    logic vd;
    logic known;
    logic [22:0] tag;
    logic [255:0] data;
  } exp_t;
  typedef struct packed {
    logic [3:0] set;
    logic [22:0] tag;
    logic [255:0] data;
  } wb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  exp_t lq0[$], lq1[$];
  wb_t wq0[$], wq1[$];
  bit mv [2][16][8];
  bit md [2][16][8];
  bit mk [2][16][8];
  logic [22:0] mt [2][16][8];
  logic [255:0] ml [2][16][8];
  longint ts [2][16][8];
  longint tick = 0;
  always #5 clk = ~clk;
  dcache_sram_nway_if #(.SETS(16), .WAYS(2), .TAG_W(23), .LINE_W(256)) b0();
  dcache_sram_nway_if #(.SETS(8), .WAYS(4), .TAG_W(8), .LINE_W(32)) b1();
  dcache_sram_nway #(.SETS(16), .WAYS(2), .TAG_W(23), .LINE_W(256)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0.slave));
  dcache_sram_nway #(.SETS(8), .WAYS(4), .TAG_W(8), .LINE_W(32)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));

  function automatic int nw(int d); return d ? 4 : 2; endfunction
  function automatic int ns(int d); return d ? 8 : 16; endfunction
  function automatic logic f_busy(int d); return d ? b1.busy_o : b0.busy_o; endfunction
  function automatic logic f_done(int d); return d ? b1.done_o : b0.done_o; endfunction
  function automatic logic f_wbv(int d); return d ? b1.wb_valid_o : b0.wb_valid_o; endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(string n, logic [255:0] act, logic [255:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
  endtask

  task automatic fail(string n);
    total_cnt++;
    $display("FAIL %s at %0t", n, $time);
  endtask

  // Reset/flush leave way w with age w: lower way index is more recently used
  function automatic void mreset(int d);
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 8; w++) begin
        mv[d][s][w] = 1'b0;
        md[d][s][w] = 1'b0;
        ts[d][s][w] = -w;
      end
  endfunction

  function automatic exp_t predict(int d, int s, logic [22:0] t);
    exp_t e;
    int v = -1;
    e = '0;
    for (int w = 0; w < nw(d); w++)
      if (mv[d][s][w] && mt[d][s][w] == t) begin
        e.hit = 1'b1;
        e.way = 3'(w);
      end
    if (!e.hit) begin
      for (int w = nw(d) - 1; w >= 0; w--) if (!mv[d][s][w]) v = w;
      if (v < 0) begin
        v = 0;
        for (int w = 1; w < nw(d); w++) if (ts[d][s][w] < ts[d][s][v]) v = w;
      end
      e.way = 3'(v);
      e.vv = mv[d][s][v];
      e.vd = mv[d][s][v] && md[d][s][v];
    end
    e.known = mk[d][s][e.way];
    e.tag = mt[d][s][e.way];
    e.data = ml[d][s][e.way];
    return e;
  endfunction

  function automatic int push_wb(int d);
    wb_t x;
    int n = 0;
    for (int s = 0; s < ns(d); s++)
      for (int w = 0; w < nw(d); w++)
        if (mv[d][s][w] && md[d][s][w]) begin
          x.set = 4'(s);
          x.tag = mt[d][s][w];
          x.data = ml[d][s][w];
          if (d) wq1.push_back(x); else wq0.push_back(x);
          n++;
        end
    return n;
  endfunction

  task automatic access(int d, bit wr, int s, logic [22:0] t, logic [255:0] dat, bit dy);
    exp_t e;
    if (d) begin
      t = t & 23'hFF;
      dat = dat & 256'hFFFF_FFFF;
    end
    e = predict(d, s, t);
    if (d) begin
      b1.req_i = 1'b1; b1.write_i = wr; b1.addr_i = s[2:0]; b1.tag_i = t[7:0]; b1.data_i = dat[31:0]; b1.dirty_i = dy;
      lq1.push_back(e);
    end else begin
      b0.req_i = 1'b1; b0.write_i = wr; b0.addr_i = s[3:0]; b0.tag_i = t; b0.data_i = dat; b0.dirty_i = dy;
      lq0.push_back(e);
    end
    @(posedge clk); #1;
    b0.req_i = 1'b0;
    b1.req_i = 1'b0;
    if (e.hit || wr) ts[d][s][e.way] = ++tick;
    if (wr) begin
      if (e.hit) md[d][s][e.way] = md[d][s][e.way] | dy;
      else begin
        mt[d][s][e.way] = t;
        mv[d][s][e.way] = 1'b1;
        md[d][s][e.way] = dy;
      end
      ml[d][s][e.way] = dat;
      mk[d][s][e.way] = 1'b1;
    end
  endtask

  task automatic set_ready(int d, logic r);
    if (d) b1.wb_ready_i = r; else b0.wb_ready_i = r;
  endtask

  task automatic flush(int d, int low);
    int n, busy = 0, done = 0, lc = 0, cyc = 0;
    logic r;
    n = push_wb(d);
    if (d) b1.flush_i = 1'b1; else b0.flush_i = 1'b1;
    while (done == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      b0.flush_i = 1'b0;
      b1.flush_i = 1'b0;
      if (f_busy(d)) busy++;
      if (f_done(d)) done++;
      r = f_wbv(d) && lc >= low;
      lc = !f_wbv(d) || r ? 0 : lc + 1;
      set_ready(d, r);
    end
    set_ready(d, 1'b0);
    chk("flush_done_pulse", done, 1);
    chk("flush_busy_cycles", busy, ns(d) * nw(d) + n * (1 + low));
    @(posedge clk); #1;
    chk("flush_done_single", f_done(d), 0);
    chk("flush_busy_after", f_busy(d), 0);
    chk("flush_wb_count", d ? wq1.size() : wq0.size(), 0);
    mreset(d);
  endtask

  task automatic check_look(int d);
    exp_t e;
    if ((d ? lq1.size() : lq0.size()) == 0) begin
      fail("lookup_unexpected");
      return;
    end
    if (d) e = lq1.pop_front(); else e = lq0.pop_front();
    chk("hit", d ? b1.hit_o : b0.hit_o, e.hit);
    chk("hit_way", d ? 3'(b1.hit_way_o) : 3'(b0.hit_way_o), e.way);
    chk("victim_valid", d ? b1.victim_valid_o : b0.victim_valid_o, e.vv);
    chk("victim_dirty", d ? b1.victim_dirty_o : b0.victim_dirty_o, e.vd);
    if (e.known) begin
      chk("tag", d ? 23'(b1.tag_o) : b0.tag_o, e.tag);
      chk("data", d ? 256'(b1.data_o) : b0.data_o, e.data);
    end
  endtask

  task automatic check_wb(int d);
    wb_t x;
    if ((d ? wq1.size() : wq0.size()) == 0) begin
      fail("wb_unexpected");
      return;
    end
    x = d ? wq1[0] : wq0[0];
    chk("wb_set", d ? 4'(b1.wb_set_o) : b0.wb_set_o, x.set);
    chk("wb_tag", d ? 23'(b1.wb_tag_o) : b0.wb_tag_o, x.tag);
    chk("wb_data", d ? 256'(b1.wb_data_o) : b0.wb_data_o, x.data);
    if (d ? b1.wb_ready_i : b0.wb_ready_i) begin
      if (d) void'(wq1.pop_front()); else void'(wq0.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (b0.req_i) check_look(0);
    if (b1.req_i) check_look(1);
    if (b0.wb_valid_o) check_wb(0);
    if (b1.wb_valid_o) check_wb(1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dn;
    {b0.req_i, b0.write_i, b0.addr_i, b0.tag_i, b0.data_i, b0.dirty_i, b0.flush_i, b0.wb_ready_i} = '0;
    {b1.req_i, b1.write_i, b1.addr_i, b1.tag_i, b1.data_i, b1.dirty_i, b1.flush_i, b1.wb_ready_i} = '0;
    for (int s = 0; s < 16; s++) for (int w = 0; w < 8; w++) mk[0][s][w] = 1'b0;
    for (int s = 0; s < 16; s++) for (int w = 0; w < 8; w++) mk[1][s][w] = 1'b0;
    mreset(0);
    mreset(1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hit", b0.hit_o, 0);
    chk("rst_hit_way", b0.hit_way_o, 0);
    chk("rst_data", b0.data_o, 0);
    chk("rst_tag", b0.tag_o, 0);
    chk("rst_victim", {b0.victim_valid_o, b0.victim_dirty_o}, 0);
    chk("rst_busy_done", {b0.busy_o, b0.done_o, b1.busy_o, b1.done_o}, 0);
    chk("rst_wb_valid", b0.wb_valid_o, 0);
    chk("rst_wb_payload", {b0.wb_set_o, b0.wb_tag_o, b0.wb_data_o}, 0);
    access(0, 0, 3, 23'h1234, '0, 0);
    access(0, 1, 5, 23'h0A, rnd256(), 0);
    access(0, 1, 5, 23'h0B, rnd256(), 0);
    access(0, 0, 5, 23'h0A, '0, 0);
    access(0, 1, 5, 23'h0C, rnd256(), 0);
    access(0, 0, 5, 23'h0B, '0, 0);
    access(0, 0, 5, 23'h0A, '0, 0);
    access(0, 1, 2, 23'h55, {32{8'hAA}}, 1);
    access(0, 1, 2, 23'h66, rnd256(), 0);
    access(0, 0, 2, 23'h66, '0, 0);
    access(0, 0, 2, 23'h77, '0, 0);
    flush(0, 0);
    access(0, 1, 0, 23'h10, rnd256(), 0);
    access(0, 1, 0, 23'h11, rnd256(), 1);
    access(0, 1, 9, 23'h12, rnd256(), 1);
    flush(0, 3);
    access(0, 0, 0, 23'h10, '0, 0);
    access(0, 0, 0, 23'h11, '0, 0);
    access(0, 0, 9, 23'h12, '0, 0);
    access(0, 1, 7, 23'h77, rnd256(), 1);
    void'(push_wb(0));
    b0.flush_i = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      b0.flush_i = 1'b0;
      cyc++;
    end while (!b0.wb_valid_o && cyc < 100);
    if (!b0.wb_valid_o) fail("rst_walk_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_wb_valid", b0.wb_valid_o, 0);
    chk("midrst_busy", b0.busy_o, 0);
    chk("midrst_done", b0.done_o, 0);
    wq0.delete();
    mreset(0);
    mreset(1);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b0.done_o) dn++;
    end
    chk("midrst_no_done", dn, 0);
    access(0, 0, 7, 23'h77, '0, 0);
    for (int t = 1; t <= 4; t++) access(1, 1, 4, 23'(t), rnd256(), 0);
    access(1, 0, 4, 23'h3, '0, 0);
    access(1, 0, 4, 23'h1, '0, 0);
    access(1, 0, 4, 23'h4, '0, 0);
    access(1, 1, 4, 23'h5, rnd256(), 1);
    access(1, 1, 4, 23'h6, rnd256(), 0);
    access(1, 0, 4, 23'h2, '0, 0);
    for (int i = 0; i < 240; i++) begin
      access(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 23'h100 + 23'($urandom_range(0, 4)), rnd256(), 1'($urandom_range(0, 1)));
      if (i % 80 == 79) flush(0, $urandom_range(0, 2));
    end
    for (int i = 0; i < 160; i++)
      access(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 23'($urandom_range(1, 6)), rnd256(), 1'($urandom_range(0, 1)));
    flush(1, 1);
    access(1, 0, 4, 23'h5, '0, 0);
    @(posedge clk); #1;
    if (lq0.size() != 0 || lq1.size() != 0) fail("lookup_queue_leftover");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dcache_sram_nway.md
# dcache_sram_nway

Parametrised N-way set-associative data-cache storage array: the next generation of the 2-way L1 data-cache SRAM, sitting between the dcache controller and the off-chip memory interface. It provides a same-cycle lookup, true-LRU replacement across WAYS ways, and per-line valid/dirty state. It also adds a hardware flush walker that writes back every dirty line through a ready/valid port and invalidates the whole array.

## Interface
- SETS, 16, number of sets; power of 2, ≥2; SET_W = clog2(SETS)
- WAYS, 2, associativity; power of 2, 2..8; WAY_W = max(1, clog2(WAYS))
- TAG_W, 23, stored tag width (no valid/dirty bits inside)
- LINE_W, 256, cache line width in bits
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  lookup/access request (qualifies all request inputs)
- write_i  in  1  1 = write/fill at this edge; 0 = lookup only
- addr_i  in  SET_W  set index
- tag_i  in  TAG_W  request tag
- data_i  in  LINE_W  write/fill line
- dirty_i  in  1  mark line dirty on write
- hit_o  out  1  tag match on a valid way
- hit_way_o  out  WAY_W  matching way on hit, victim way on miss
- data_o  out  LINE_W  hit line on hit, victim line on miss
- tag_o  out  TAG_W  hit tag on hit, victim tag on miss
- victim_valid_o / victim_dirty_o  out  1 each  victim state; 0 on hit
- flush_i  in  1  start flush walk (single-cycle pulse)
- busy_o  out  1  walk in progress; requests ignored
- done_o  out  1  one-cycle pulse at walk end
- wb_valid_o  out  1  write-back payload valid
- wb_ready_i  in  1  memory accepts write-back
- wb_set_o / wb_tag_o / wb_data_o  out  SET_W / TAG_W / LINE_W  write-back payload

## Operation
- Storage per (set,way): tag, line, valid, dirty, age (WAY_W bits). Reset clears valid, dirty, ages to way index w → age w; tag/line arrays not cleared.
- Lookup (combinational, active when req_i=1 and busy_o=0): hit if any valid way has tag == tag_i. At most one way can match.
- Victim select on miss: lowest-index invalid way; if all valid, way with age == WAYS-1.
- Outputs forced to 0 when req_i=0 or busy_o=1.
- Write at edge (req_i & write_i & !busy_o):
  - Hit: line ← data_i; dirty ← dirty | dirty_i; tag unchanged.
  - Miss: fill victim: tag ← tag_i, line ← data_i, valid ← 1, dirty ← dirty_i.
- LRU update on every accepted access (read hit, write hit, fill); read miss does not update. The touched way takes age 0, and each way with age < old age of the touched way increments. Ages remain a permutation of 0..WAYS-1.
- Flush FSM: IDLE → SCAN on flush_i with busy_o=0. SCAN visits (set,way) in order set 0 way 0 … set SETS-1 way WAYS-1.
  - Entry valid & dirty: go to WB, wb_valid_o=1 with that entry's set/tag/line held stable.
  - WB: when wb_ready_i=1 is sampled, clear that entry and return to SCAN at the next entry.
  - Entry not dirty: clear valid, advance, 1 cycle per entry.
  - After the last entry: DONE for 1 cycle with done_o=1 and busy_o=0, then IDLE. Ages are reset as on rst_i.
- flush_i while busy_o=1 is ignored. flush_i in the same cycle as an accepted write: the write completes at that edge, and the walk starts next cycle.

## Timing
- Lookup outputs are valid in the same cycle as req_i/addr_i/tag_i. Write effects are visible the cycle after the edge.
- busy_o rises the cycle after flush_i. With no dirty lines, busy_o stays high exactly SETS·WAYS cycles.
- Each dirty line adds 1 WB cycle plus the number of cycles wb_ready_i is low. wb_valid_o drops the cycle after the handshake.
- Reset values: hit_o, data_o, tag_o, hit_way_o, victim_*, busy_o, done_o, wb_valid_o all 0. wb_* payload is 0.
- rst_i mid-walk: next cycle FSM is IDLE, wb_valid_o=0, no done_o, and all lines are invalid.

## Test plan
- Reset, then lookup set 3 tag 0x1234 → hit_o=0, victim_valid_o=0, hit_way_o=0.
- Set 5: fill tag A (way0) then B (way1), read A → hit, hit_way_o=0. Fill C → replaces way1 (B); lookup B misses, A hits.
- Write set 2 tag 0x55 data 0xAA..AA dirty_i=1, fill a second way, touch it, then miss with a new tag → victim_dirty_o=1, tag_o=0x55, data_o=0xAA..AA.
- Two dirty lines (set 0 way1, set 9 way0), flush with wb_ready_i held low 3 cycles per line. Expect: two handshakes in set order with stable payload, busy_o high 32+2+6 cycles, one done_o pulse, and all later lookups miss.
- rst_i asserted while wb_valid_o=1 → next cycle wb_valid_o=0, busy_o=0, done_o never pulses, lookups miss.
- WAYS=4, SETS=8: fill ways 0-3, touch 2,0,3. Next fill evicts way 1, then way 2.
